// File: rtl/data_memory_dumper_pkg.sv
// Shared debug-unit FSM codes for the data-memory dump stage.
// The numeric values are fixed so that other debug-unit blocks can decode them.
package data_memory_dumper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_SEND = 3'd3,
    ST_DONE = 3'd4
  } dump_state_e;

endpackage

// File: rtl/data_memory_dumper.sv
// Walks the data memory from address 0 to MEMORY_DEPTH-1 through its debug read port
// and streams each byte to the UART TX path over a valid/ready handshake.
module data_memory_dumper #(
  parameter int MEMORY_WIDTH = 8,
  parameter int MEMORY_DEPTH = 128,
  parameter int NB_ADDR      = 7
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  output logic                    o_mem_read_enable,
  output logic [NB_ADDR-1:0]      o_mem_read_address,
  input  logic [MEMORY_WIDTH-1:0] i_mem_byte_data,
  output logic [MEMORY_WIDTH-1:0] o_tx_data,
  output logic                    o_tx_valid,
  input  logic                    i_tx_ready,
  output logic                    o_busy,
  output logic                    o_done
);
  import data_memory_dumper_pkg::*;

  // Terminal compare is against the real depth, so the counter never wraps.
  localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(MEMORY_DEPTH - 1);

  dump_state_e             state;
  dump_state_e             state_next;
  logic [NB_ADDR-1:0]      addr;
  logic [MEMORY_WIDTH-1:0] tx_data;
  logic                    at_last;
  logic                    accepted;

  assign at_last  = (addr == LAST_ADDR);
  assign accepted = (state == ST_SEND) && i_tx_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: state_next is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (i_abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (i_start) state_next = ST_REQ;
        ST_REQ:  state_next = ST_WAIT;
        ST_WAIT: state_next = ST_SEND;
        ST_SEND: if (i_tx_ready) state_next = at_last ? ST_DONE : ST_REQ;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      addr <= '0;
    end else if (!i_abort) begin
      if (state == ST_IDLE && i_start) begin
        addr <= '0;
      end else if (accepted && !at_last) begin
        addr <= addr + NB_ADDR'(1);
      end
    end
  end

  // The memory byte is only valid in the cycle after the read enable.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_data <= '0;
    end else if (state == ST_WAIT && !i_abort) begin
      tx_data <= i_mem_byte_data;
    end
  end

  assign o_mem_read_enable  = (state == ST_REQ);
  assign o_mem_read_address = addr;
  assign o_tx_data          = tx_data;
  assign o_tx_valid         = (state == ST_SEND);
  assign o_busy             = (state == ST_REQ) || (state == ST_WAIT) || (state == ST_SEND);
  assign o_done             = (state == ST_DONE);

endmodule

// File: tb/tb_data_memory_dumper.sv
// Bench for data_memory_dumper: a 1-cycle-latency memory stand-in, a schedule-level
// reference model and scoreboard checked every cycle, plus directed and random dumps.
module tb_data_memory_dumper;
  localparam int W = 8;
  localparam int D = 128;
  localparam int A = 7;

  logic         clock    = 1'b0;
  logic         rst_n    = 1'b1;
  logic         start    = 1'b0;
  logic         abort    = 1'b0;
  logic         tx_ready = 1'b0;
  logic         mem_re;
  logic [A-1:0] mem_addr;
  logic [W-1:0] mem_byte = '0;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         busy;
  logic         done;

  always #5 clock = ~clock;

  data_memory_dumper #(.MEMORY_WIDTH(W), .MEMORY_DEPTH(D), .NB_ADDR(A)) dut (
    .i_clock           (clock),
    .i_reset_n         (rst_n),
    .i_start           (start),
    .i_abort           (abort),
    .o_mem_read_enable (mem_re),
    .o_mem_read_address(mem_addr),
    .i_mem_byte_data   (mem_byte),
    .o_tx_data         (tx_data),
    .o_tx_valid        (tx_valid),
    .i_tx_ready        (tx_ready),
    .o_busy            (busy),
    .o_done            (done)
  );

  logic [W-1:0] mem [D];
  always @(posedge clock) if (mem_re) mem_byte <= mem[mem_addr];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: schedule of a dump expressed as event times.
  bit           m_active    = 0;
  int           cyc         = 0;
  int           m_req_at    = -1;
  int           m_valid_from = -1;
  int           m_done_at   = -1;
  int           m_start_cyc = 0;
  int           m_idx       = 0;
  int           m_busy_cycles = 0;
  int           m_done_rel  = 0;
  int           dut_done_pulses = 0;
  logic [W-1:0] acc_log [$];
  bit           rand_ready  = 0;

  always @(negedge clock) begin
    bit exp_re, exp_valid;
    cyc++;
    if (done === 1'b1) dut_done_pulses++;
    if (!rst_n) begin
      check("rst_re", 32'(mem_re), 0);
      check("rst_addr", 32'(mem_addr), 0);
      check("rst_data", 32'(tx_data), 0);
      check("rst_valid", 32'(tx_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      m_active  = 0;
      m_done_at = -1;
    end else begin
      exp_re    = m_active && (cyc == m_req_at);
      exp_valid = m_active && (cyc >= m_valid_from);
      check("cyc_re", 32'(mem_re), 32'(exp_re));
      if (exp_re) check("cyc_addr", 32'(mem_addr), 32'(m_idx));
      check("cyc_valid", 32'(tx_valid), 32'(exp_valid));
      if (exp_valid) check("cyc_data", 32'(tx_data), 32'(mem[m_idx]));
      check("cyc_busy", 32'(busy), 32'(m_active));
      check("cyc_done", 32'(done), 32'(cyc == m_done_at));
      if (m_active) m_busy_cycles++;

      if (abort) begin
        m_active  = 0;
        m_done_at = -1;
      end else if (!m_active && cyc != m_done_at && start) begin
        m_active      = 1;
        m_idx         = 0;
        m_start_cyc   = cyc;
        m_req_at      = cyc + 1;
        m_valid_from  = cyc + 3;
        m_busy_cycles = 0;
        acc_log.delete();
      end else if (exp_valid && tx_ready) begin
        acc_log.push_back(tx_data);
        if (m_idx == D - 1) begin
          m_active   = 0;
          m_done_at  = cyc + 1;
          m_done_rel = m_done_at - m_start_cyc;
        end else begin
          m_idx++;
          m_req_at     = cyc + 1;
          m_valid_from = cyc + 3;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_ready) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic start_dump();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (m_active && n < limit) begin
      step();
      n++;
    end
    if (m_active) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: still busy after %0d cycles", limit);
      abort = 1'b1;
      step();
      abort = 1'b0;
    end
    step();
    step();
  endtask

  task automatic wait_cond_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not seen within budget", name);
  endtask

  initial begin
    int n;
    int pulses_before;
    for (int k = 0; k < D; k++) mem[k] = W'(k) ^ 8'hA5;

    // Reset
    #1 rst_n = 1'b0;
    #1;
    check("reset_re", 32'(mem_re), 0);
    check("reset_addr", 32'(mem_addr), 0);
    check("reset_data", 32'(tx_data), 0);
    check("reset_valid", 32'(tx_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    step();

    // Full dump, always ready
    tx_ready = 1'b1;
    start_dump();
    wait_idle(1000);
    check("full_done_cycle", 32'(m_done_rel), 385);
    check("full_busy_cycles", 32'(m_busy_cycles), 384);
    check("full_count", 32'(acc_log.size()), 128);
    check("full_first_byte", 32'(acc_log[0]), 32'h0A5);
    check("full_last_byte", 32'(acc_log[127]), 32'h0DA);

    // Backpressure on byte 3
    mem[3] = 8'h3C;
    start_dump();
    n = 0;
    while (!(tx_valid && tx_data == 8'h3C) && n < 50) begin step(); n++; end
    if (n >= 50) wait_cond_timeout("bp_reach_byte3");
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", 32'(tx_data), 32'h3C);
      check("bp_hold_valid", 32'(tx_valid), 1);
      check("bp_no_req", 32'(mem_re), 0);
      step();
    end
    tx_ready = 1'b1;
    wait_idle(1000);
    check("bp_done_cycle", 32'(m_done_rel), 390);
    check("bp_byte3", 32'(acc_log[3]), 32'h3C);
    mem[3] = 8'h03 ^ 8'hA5;

    // Abort in SEND of byte 10, then restart
    start_dump();
    n = 0;
    while (!(tx_valid && acc_log.size() == 10) && n < 100) begin step(); n++; end
    if (n >= 100) wait_cond_timeout("abort_reach_byte10");
    pulses_before = dut_done_pulses;
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_valid", 32'(tx_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_re", 32'(mem_re), 0);
    repeat (5) step();
    check("abort_no_done", 32'(dut_done_pulses), 32'(pulses_before));
    rand_ready = 1;
    start_dump();
    check("restart_addr", 32'(mem_addr), 0);
    check("restart_re", 32'(mem_re), 1);
    wait_idle(3000);
    check("restart_count", 32'(acc_log.size()), 128);
    rand_ready = 0;
    tx_ready   = 1'b1;

    // Start ignored mid-dump; start with abort in IDLE
    start_dump();
    n = 0;
    while (acc_log.size() != 20 && n < 200) begin step(); n++; end
    if (n >= 200) wait_cond_timeout("ign_reach_byte20");
    start = 1'b1;
    step();
    start = 1'b0;
    wait_idle(1000);
    check("ign_done_cycle", 32'(m_done_rel), 385);
    check("ign_count", 32'(acc_log.size()), 128);
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("conflict_busy", 32'(busy), 0);
    check("conflict_re", 32'(mem_re), 0);
    step();
    check("conflict_busy2", 32'(busy), 0);

    // Async reset in WAIT of byte 50
    start_dump();
    n = 0;
    while (!(mem_re && mem_addr == 7'd50) && n < 400) begin step(); n++; end
    if (n >= 400) wait_cond_timeout("rst_reach_byte50");
    step();
    #2 rst_n = 1'b0;
    #1;
    check("async_re", 32'(mem_re), 0);
    check("async_addr", 32'(mem_addr), 0);
    check("async_data", 32'(tx_data), 0);
    check("async_valid", 32'(tx_valid), 0);
    check("async_busy", 32'(busy), 0);
    check("async_done", 32'(done), 0);
    pulses_before = dut_done_pulses;
    @(posedge clock);
    #1 rst_n = 1'b1;
    step();
    check("post_rst_busy", 32'(busy), 0);
    check("post_rst_addr", 32'(mem_addr), 0);
    check("post_rst_no_done", 32'(dut_done_pulses), 32'(pulses_before));

    // Random contents, random backpressure, occasional random abort
    rand_ready = 1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < D; k++) mem[k] = W'($urandom);
      start_dump();
      if (r == 2) begin
        repeat ($urandom_range(5, 200)) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("rand_abort_busy", 32'(busy), 0);
        step();
      end else begin
        wait_idle(3000);
        check("rand_count", 32'(acc_log.size()), 128);
      end
    end
    rand_ready = 0;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
